// File: rtl/lm_sm_pkg.sv
// Shared definitions for the LM/SM register-list sequencer.
// The register count and index width are also used by the register-file
// and datapath select logic, so they live here rather than in the sequencer.
package lm_sm_pkg;

   localparam int NREG = 8;
   localparam int IDXW = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } lm_sm_state_e;

endpackage : lm_sm_pkg

// File: rtl/lm_sm_sequencer_if.sv
// Handshake bundle between the main controller (master) and the LM/SM
// register-list sequencer (slave).
interface lm_sm_sequencer_if
   import lm_sm_pkg::*;
#(
   parameter int NREG_P = NREG,
   parameter int IDXW_P = IDXW
);

   logic              start;
   logic [NREG_P-1:0] reg_list;
   logic              adv;
   logic              busy;
   logic              xfer_valid;
   logic [IDXW_P-1:0] lm_sm_wadd;
   logic [IDXW_P-1:0] counter;
   logic              done;

   modport master (
      output start, reg_list, adv,
      input  busy, xfer_valid, lm_sm_wadd, counter, done
   );

   modport slave (
      input  start, reg_list, adv,
      output busy, xfer_valid, lm_sm_wadd, counter, done
   );

endinterface : lm_sm_sequencer_if

// File: rtl/lm_sm_sequencer_prio_enc8.sv
// 8-bit lowest-set-bit priority encoder. Picks the lowest pending register
// so the sequencer always walks the list in ascending order.
module prio_enc8 (
   input  logic [7:0] i_vec,
   output logic [2:0] o_idx,
   output logic       o_any
);

   // Scan from the top down so the last match written is the lowest set bit.
   always_comb begin
      o_idx = 3'd0;
      o_any = |i_vec;
      for (int i = 7; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = 3'(i);
         end
      end
   end

endmodule : prio_enc8

// File: rtl/lm_sm_sequencer.sv
// LM/SM register-list sequencer. Latches the register list on start,
// presents one register index plus a running memory offset per transfer,
// advances on the controller's adv handshake and pulses done at the end.
// Every output is decoded from registered state only.
module lm_sm_sequencer
   import lm_sm_pkg::*;
#(
   parameter int NREG_P = NREG,
   parameter int IDXW_P = IDXW
) (
   input logic               clk,
   input logic               proc_rst,
   lm_sm_sequencer_if.slave  bus
);

   lm_sm_state_e      r_state;
   lm_sm_state_e      w_nextState;
   logic [NREG_P-1:0] r_mask;
   logic [NREG_P-1:0] w_nextMask;
   logic [IDXW_P-1:0] r_offset;
   logic [IDXW_P-1:0] w_nextOffset;

   logic [2:0]        w_idx;
   logic              w_any;
   logic [NREG_P-1:0] w_lowBit;
   logic [NREG_P-1:0] w_maskCleared;

   prio_enc8 u_prioEnc (
      .i_vec (r_mask),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Isolate and drop the lowest pending register for the next slot.
   always_comb begin
      w_lowBit      = r_mask & (~r_mask + NREG_P'(1));
      w_maskCleared = r_mask & ~w_lowBit;
   end

   // State, pending mask and offset registers; reset abandons any sequence.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         r_state  <= IDLE;
         r_mask   <= '0;
         r_offset <= '0;
      end else begin
         r_state  <= w_nextState;
         r_mask   <= w_nextMask;
         r_offset <= w_nextOffset;
      end
   end

   // Next-state logic: accept start only in IDLE, advance only in ACTIVE.
   always_comb begin
      w_nextState  = r_state;
      w_nextMask   = r_mask;
      w_nextOffset = r_offset;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_nextMask   = bus.reg_list;
               w_nextOffset = '0;
               w_nextState  = (|bus.reg_list) ? ACTIVE : DONE;
            end
         end
         ACTIVE: begin
            // An empty mask here is unreachable; finishing is the safe recovery.
            if (!w_any) begin
               w_nextState = DONE;
            end else if (bus.adv) begin
               w_nextMask   = w_maskCleared;
               w_nextOffset = r_offset + IDXW_P'(1);
               if (w_maskCleared == '0) begin
                  w_nextState = DONE;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output decode from registered state; the index is forced to 0 outside ACTIVE.
   always_comb begin
      bus.busy       = (r_state == ACTIVE) || (r_state == DONE);
      bus.xfer_valid = (r_state == ACTIVE);
      bus.lm_sm_wadd = (r_state == ACTIVE) ? IDXW_P'(w_idx) : '0;
      bus.counter    = r_offset;
      bus.done       = (r_state == DONE);
   end

endmodule : lm_sm_sequencer

// File: tb/tb_lm_sm_sequencer.sv
// Directed testbench for the LM/SM register-list sequencer.
module tb_lm_sm_sequencer;
   import lm_sm_pkg::*;

   logic clk;
   logic proc_rst;
   int   testsRun;
   int   testsFailed;

   lm_sm_sequencer_if #(.NREG_P(NREG), .IDXW_P(IDXW)) bus ();

   lm_sm_sequencer #(.NREG_P(NREG), .IDXW_P(IDXW)) dut (
      .clk      (clk),
      .proc_rst (proc_rst),
      .bus      (bus)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic [7:0] regList, input logic adv);
      bus.start    = start;
      bus.reg_list = regList;
      bus.adv      = adv;
   endtask

   task automatic checkOutput(input string tag, input logic expBusy, input logic expValid,
                              input logic [2:0] expWadd, input logic [2:0] expCounter,
                              input logic expDone);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = {bus.busy, bus.xfer_valid, bus.lm_sm_wadd, bus.counter, bus.done};
      exp = {expBusy, expValid, expWadd, expCounter, expDone};
      testsRun++;
      assert (obs === exp)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed={busy,valid,wadd,counter,done}=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Linear sequence of directed steps with hand-computed expectations.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      proc_rst    = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("reset_outputs", 0, 0, 3'd0, 3'd0, 0);
      tick();
      tick();
      proc_rst = 1'b1;
      tick();
      checkOutput("idle_after_reset", 0, 0, 3'd0, 3'd0, 0);

      // 8'b1010_0101 with adv every cycle
      applyStimulus(1'b1, 8'hA5, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("a5_slot0", 1, 1, 3'd0, 3'd0, 0);
      tick();
      checkOutput("a5_slot1", 1, 1, 3'd2, 3'd1, 0);
      tick();
      checkOutput("a5_slot2", 1, 1, 3'd5, 3'd2, 0);
      tick();
      checkOutput("a5_slot3", 1, 1, 3'd7, 3'd3, 0);
      tick();
      checkOutput("a5_done", 1, 0, 3'd0, 3'd4, 1);
      tick();
      checkOutput("a5_idle", 0, 0, 3'd0, 3'd4, 0);
      tick();
      checkOutput("adv_in_idle_ignored", 0, 0, 3'd0, 3'd4, 0);

      // Empty list goes straight to DONE
      applyStimulus(1'b1, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("empty_done", 1, 0, 3'd0, 3'd0, 1);
      tick();
      checkOutput("empty_idle", 0, 0, 3'd0, 3'd0, 0);

      // Full list, offset wraps on the last advance
      applyStimulus(1'b1, 8'hFF, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("ff_slot%0d", i), 1, 1, 3'(i), 3'(i), 0);
         tick();
      end
      checkOutput("ff_done_wrap", 1, 0, 3'd0, 3'd0, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("ff_idle", 0, 0, 3'd0, 3'd0, 0);

      // 8'b0001_0010 with a three-cycle stall on the first slot
      applyStimulus(1'b1, 8'h12, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("stall_slot0", 1, 1, 3'd1, 3'd0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("stall_hold%0d", i), 1, 1, 3'd1, 3'd0, 0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checkOutput("stall_slot1", 1, 1, 3'd4, 3'd1, 0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("stall_done", 1, 0, 3'd0, 3'd2, 1);
      tick();
      checkOutput("stall_idle", 0, 0, 3'd0, 3'd2, 0);

      // start while ACTIVE must not disturb the latched list
      applyStimulus(1'b1, 8'h30, 1'b0);
      tick();
      checkOutput("restart_slot0", 1, 1, 3'd4, 3'd0, 0);
      applyStimulus(1'b1, 8'h0F, 1'b1);
      tick();
      checkOutput("restart_slot1", 1, 1, 3'd5, 3'd1, 0);
      tick();
      checkOutput("restart_done", 1, 0, 3'd0, 3'd2, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("restart_idle", 0, 0, 3'd0, 3'd2, 0);

      // Asynchronous reset in the middle of slot 2 of 8'hF0
      applyStimulus(1'b1, 8'hF0, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rst_seq_slot0", 1, 1, 3'd4, 3'd0, 0);
      tick();
      checkOutput("rst_seq_slot1", 1, 1, 3'd5, 3'd1, 0);
      #2;
      proc_rst = 1'b0;
      #1;
      checkOutput("rst_async_zero", 0, 0, 3'd0, 3'd0, 0);
      tick();
      checkOutput("rst_held_no_done", 0, 0, 3'd0, 3'd0, 0);
      proc_rst = 1'b1;
      applyStimulus(1'b1, 8'h01, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("post_rst_slot0", 1, 1, 3'd0, 3'd0, 0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("post_rst_done", 1, 0, 3'd0, 3'd1, 1);
      tick();
      checkOutput("post_rst_idle", 0, 0, 3'd0, 3'd1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule : tb_lm_sm_sequencer

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Register-list sequencer for the multi-register load and store instructions (LM/SM). When the main controller starts an LM/SM, this block walks the 8-bit register list in IR[7:0] and presents one register per transfer. For each transfer it drives the `lm_sm_wadd` register index and the `counter` memory-offset inputs of the datapath. It advances on a handshake from the controller and pulses `done` when the list is exhausted.

## Interface
- `NREG`, default 8: number of architectural registers, which is also the width of the register list.
- `IDXW`, default 3: width of the register index and the offset, equal to log2(`NREG`).

- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `proc_rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a sequence. Accepted only in IDLE.
- `reg_list` input, `NREG` bits: register list, normally IR[7:0]. Bit i set means register i takes part. Sampled only on an accepted `start`.
- `adv` input, 1 bit: the controller has completed the currently presented transfer. Honoured only when `xfer_valid` is 1.
- `busy` output, 1 bit: high in ACTIVE and DONE.
- `xfer_valid` output, 1 bit: a transfer slot is being presented.
- `lm_sm_wadd` output, `IDXW` bits: register index of the current slot. It feeds both the RF write address and the RF read-2 address.
- `counter` output, `IDXW` bits: count of transfers already completed in this sequence. It is the memory offset added to the base address.
- `done` output, 1 bit: one-cycle pulse marking the end of the sequence.

## Operation
- Internal state:
  - `state` ∈ {IDLE, ACTIVE, DONE}.
  - `mask`: `NREG` bits of pending registers.
  - `offset`: `IDXW` bits.
- IDLE:
  - `start`=1 → latch `mask`=`reg_list` and clear `offset`=0.
  - Next state is ACTIVE if `reg_list`≠0, otherwise DONE.
  - `start`=0 → stay in IDLE.
- ACTIVE:
  - `xfer_valid`=1.
  - `lm_sm_wadd` = index of the lowest set bit of `mask`. This is combinational from `mask`, so registers are always visited in ascending order.
  - `counter`=`offset`.
  - `adv`=1 → clear that bit of `mask` and increment `offset`. If the cleared `mask` becomes 0, go to DONE; otherwise stay in ACTIVE and present the next slot on the following cycle.
  - `adv`=0 → hold all outputs stable, with no limit on the stall length.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- Ignored inputs:
  - `start` in ACTIVE or DONE has no effect. The latched list is not disturbed.
  - `adv` in IDLE or DONE has no effect.
- Width rules:
  - `offset` increments modulo 2^`IDXW`.
  - With `reg_list`=0xFF the last slot presents `counter`=7. The following increment wraps `offset` to 0, which is harmless because the sequence ends at that point.
- Outputs outside ACTIVE:
  - `xfer_valid`=0 and `lm_sm_wadd`=0.
  - `counter` shows `offset`: the final count in DONE, that same value while IDLE, and 0 after `start` or reset.
- Reset (`proc_rst`=0):
  - Asynchronous: immediately `state`=IDLE, `mask`=0, `offset`=0.
  - All outputs go to 0, including mid-sequence. The interrupted sequence is abandoned with no `done` pulse.

## Timing
- `start` accepted at edge k:
  - Non-empty list: first slot presented in cycle k+1.
  - Empty list: `done` in cycle k+1.
- One transfer is completed per edge on which `adv` is 1 in ACTIVE. Minimum length is 1 cycle per transfer.
- `done` is high in the cycle after the edge that completes the last transfer.
- Best case from `start` to `done`: popcount(`reg_list`)+1 edges.
- Earliest next `start` acceptance: the cycle after `done`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start`, `adv` or `reg_list` to any output.

## Structure
- Shared package/include `lm_sm_pkg` contains:
  - the state encoding: IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2;
  - the `NREG`/`IDXW` constants, shared with the register-file and datapath select widths.
- One sub-module `prio_enc8`: 8-bit lowest-set-bit encoder with outputs `idx[2:0]` and `any`. It is purely combinational and drives `lm_sm_wadd` and the empty test.

## Test plan
- `reg_list`=8'b1010_0101, `adv`=1 every cycle:
  - (`lm_sm_wadd`,`counter`) = (0,0),(2,1),(5,2),(7,3) on consecutive cycles.
  - `done` on the next cycle, then `busy`=0.
- `reg_list`=8'h00:
  - `done` in cycle k+1; `xfer_valid` never asserted.
- `reg_list`=8'hFF:
  - Eight slots with `lm_sm_wadd`=`counter`=0..7.
  - `done` after slot 7; `counter` reads 0 in the DONE cycle (wrap).
- `reg_list`=8'b0001_0010 with `adv` held low 3 cycles on slot 1:
  - `lm_sm_wadd`=1 and `counter`=0 stay stable throughout the stall.
  - Then (4,1), then `done`.
- `start` pulsed with `reg_list`=8'h0F while ACTIVE on a sequence started with 8'h30:
  - The sequence continues with wadd 4, 5 only.
- `proc_rst` asserted asynchronously mid-cycle during slot 2 of 8'hF0:
  - All outputs 0 immediately with no `done` pulse.
  - After release, a fresh `start` with 8'h01 gives a single slot (0,0).
